// File: rtl/range_pkg.sv
// Constants shared by the range-finder core, its input conditioner and the display path.
package range_pkg;

    localparam int RANGE_DATA_W           = 4;
    localparam int RANGE_DEBOUNCE_DEFAULT = 4;

    // Width of a counter that must be able to hold the value `cycles`.
    function automatic int count_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchronizer followed by a persistence debouncer; the whole vector moves as one unit.
module debounce_sync
    import range_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int CYCLES = RANGE_DEBOUNCE_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable,
    output logic [WIDTH-1:0] rise
);

    localparam int CW = count_width(CYCLES);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] synced;
    logic [WIDTH-1:0] prev;
    logic [CW-1:0]    count;
    logic [CW-1:0]    run;
    logic             update;

    // The cycle in which the synced value changes is the first cycle of its run,
    // so a clean edge reaches `stable` exactly CYCLES edges after it is synced.
    always_comb begin
        run    = (synced != prev) ? CW'(1) : count + CW'(1);
        update = (synced != stable) && (run == CW'(CYCLES));
        rise   = update ? (synced & ~stable) : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            meta   <= '0;
            synced <= '0;
            prev   <= '0;
            stable <= '0;
            count  <= '0;
        end else begin
            meta   <= raw;
            synced <= meta;
            prev   <= synced;
            if (synced == stable) begin
                count <= '0;
            end else if (update) begin
                stable <= synced;
                count  <= '0;
            end else begin
                count <= run;
            end
        end
    end

endmodule

// File: rtl/range_input_conditioner.sv
// Board-input front end: clean single-cycle go/finish pulses, held data, and frame-state tracking.
module range_input_conditioner
    import range_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = RANGE_DEBOUNCE_DEFAULT,
    parameter int DATA_W          = RANGE_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              go_raw,
    input  logic              finish_raw,
    input  logic [DATA_W-1:0] data_raw,
    output logic              go_pulse,
    output logic              finish_pulse,
    output logic [DATA_W-1:0] data_out,
    output logic              frame_active,
    output logic              orphan_finish
);

    logic              go_rise;
    logic              finish_rise;
    logic              go_pending;
    logic              go_stable_unused;
    logic              finish_stable_unused;
    logic [DATA_W-1:0] data_rise_unused;

    debounce_sync #(.WIDTH(1), .CYCLES(DEBOUNCE_CYCLES)) u_go (
        .clock  (clock),
        .reset  (reset),
        .raw    (go_raw),
        .stable (go_stable_unused),
        .rise   (go_rise)
    );

    debounce_sync #(.WIDTH(1), .CYCLES(DEBOUNCE_CYCLES)) u_finish (
        .clock  (clock),
        .reset  (reset),
        .raw    (finish_raw),
        .stable (finish_stable_unused),
        .rise   (finish_rise)
    );

    debounce_sync #(.WIDTH(DATA_W), .CYCLES(DEBOUNCE_CYCLES)) u_data (
        .clock  (clock),
        .reset  (reset),
        .raw    (data_raw),
        .stable (data_out),
        .rise   (data_rise_unused)
    );

    // Finish wins a collision; the go waits one slot in go_pending, and extra go rises are dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            go_pulse      <= 1'b0;
            finish_pulse  <= 1'b0;
            go_pending    <= 1'b0;
            frame_active  <= 1'b0;
            orphan_finish <= 1'b0;
        end else begin
            go_pulse     <= 1'b0;
            finish_pulse <= 1'b0;
            if (finish_rise) begin
                finish_pulse <= 1'b1;
                if (go_rise) begin
                    go_pending <= 1'b1;
                end
            end else if (go_pending) begin
                go_pulse   <= 1'b1;
                go_pending <= 1'b0;
            end else if (go_rise) begin
                go_pulse <= 1'b1;
            end

            if (go_pulse) begin
                frame_active  <= 1'b1;
                orphan_finish <= 1'b0;
            end else if (finish_pulse) begin
                frame_active <= 1'b0;
                if (!frame_active) begin
                    orphan_finish <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_range_input_conditioner.sv
// Directed bench for range_input_conditioner with the default debounce of 4 cycles.
module tb_range_input_conditioner;

    logic       clock = 1'b0;
    logic       reset;
    logic       go_raw;
    logic       finish_raw;
    logic [3:0] data_raw;
    logic       go_pulse;
    logic       finish_pulse;
    logic [3:0] data_out;
    logic       frame_active;
    logic       orphan_finish;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];

    range_input_conditioner dut (
        .clock         (clock),
        .reset         (reset),
        .go_raw        (go_raw),
        .finish_raw    (finish_raw),
        .data_raw      (data_raw),
        .go_pulse      (go_pulse),
        .finish_pulse  (finish_pulse),
        .data_out      (data_out),
        .frame_active  (frame_active),
        .orphan_finish (orphan_finish)
    );

    always #5 clock = ~clock;

    // Status byte: [7] go_pulse, [6] finish_pulse, [5] frame_active, [4] orphan_finish, [3:0] data_out.
    function automatic logic [7:0] status();
        return {go_pulse, finish_pulse, frame_active, orphan_finish, data_out};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Advance n edges and require that no pulse of either kind appeared.
    task automatic quiet(input int n, input string tag);
        int p;
        p = 0;
        for (int i = 0; i < n; i++) begin
            step();
            p += int'(go_pulse) + int'(finish_pulse);
        end
        check(tag, 8'(p), 8'd0);
    endtask

    initial begin
        int         bp;
        int         dev;
        logic [7:0] exp_v;

        reset      = 1'b1;
        go_raw     = 1'b0;
        finish_raw = 1'b0;
        data_raw   = 4'h0;
        repeat (3) step();
        check("reset_hold", status(), 8'h00);
        reset = 1'b0;
        step();
        check("post_reset", status(), 8'h00);

        // Clean go press held 20 cycles.
        go_raw = 1'b1;
        quiet(5, "go_pre");
        step();
        check("go_edge6", status(), 8'h80);
        step();
        check("go_edge7", status(), 8'h20);
        quiet(13, "go_hold");
        go_raw = 1'b0;
        quiet(10, "go_release");
        check("go_released", status(), 8'h20);

        // Bouncy finish: 1,0,1,0 on single cycles, then held high.
        bp = 0;
        for (int i = 0; i < 4; i++) begin
            finish_raw = (i % 2 == 0);
            step();
            bp += int'(go_pulse) + int'(finish_pulse);
        end
        check("fin_bounce", 8'(bp), 8'd0);
        finish_raw = 1'b1;
        quiet(5, "fin_pre");
        step();
        check("fin_edge6", status(), 8'h60);
        step();
        check("fin_edge7", status(), 8'h00);
        finish_raw = 1'b0;
        quiet(10, "fin_release");

        // Open a frame, then collide go and finish.
        go_raw = 1'b1;
        quiet(5, "go2_pre");
        step();
        check("go2_edge6", status(), 8'h80);
        go_raw = 1'b0;
        quiet(10, "go2_release");
        go_raw     = 1'b1;
        finish_raw = 1'b1;
        quiet(5, "coll_pre");
        step();
        check("coll_edge6", status(), 8'h60);
        step();
        check("coll_edge7", status(), 8'h80);
        step();
        check("coll_edge8", status(), 8'h20);
        go_raw     = 1'b0;
        finish_raw = 1'b0;
        quiet(10, "coll_release");

        // Close the frame normally, then a finish with no frame is an orphan.
        finish_raw = 1'b1;
        quiet(5, "close_pre");
        step();
        check("close_edge6", status(), 8'h60);
        step();
        check("close_edge7", status(), 8'h00);
        finish_raw = 1'b0;
        quiet(10, "close_release");
        finish_raw = 1'b1;
        quiet(5, "orph_pre");
        step();
        check("orph_edge6", status(), 8'h40);
        step();
        check("orph_set", status(), 8'h10);
        finish_raw = 1'b0;
        quiet(10, "orph_release");
        check("orph_sticky", status(), 8'h10);
        go_raw = 1'b1;
        quiet(5, "orph_go_pre");
        step();
        check("orph_go_edge6", status(), 8'h90);
        step();
        check("orph_clear", status(), 8'h20);
        go_raw = 1'b0;
        quiet(10, "orph_go_release");

        // Data path: settle on 0x3, step to 0xA, then a 2-cycle glitch to 0xF.
        data_raw = 4'h3;
        exp_q.push_back(8'h03);
        quiet(10, "data_settle");
        exp_v = exp_q.pop_front();
        check("data_3", 8'(data_out), exp_v);
        data_raw = 4'hA;
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h0A);
        repeat (5) step();
        exp_v = exp_q.pop_front();
        check("data_pre", 8'(data_out), exp_v);
        step();
        exp_v = exp_q.pop_front();
        check("data_edge6", 8'(data_out), exp_v);
        dev = 0;
        data_raw = 4'hF;
        for (int i = 0; i < 2; i++) begin
            step();
            dev += int'(data_out != 4'hA);
        end
        data_raw = 4'hA;
        for (int i = 0; i < 10; i++) begin
            step();
            dev += int'(data_out != 4'hA);
        end
        check("data_glitch", 8'(dev), 8'd0);
        check("data_hold", status(), 8'h2A);

        // Reset in the middle of a go debounce; go and data stay driven.
        go_raw = 1'b1;
        repeat (3) step();
        reset = 1'b1;
        step();
        check("mid_reset", status(), 8'h00);
        reset = 1'b0;
        quiet(5, "mid_pre");
        check("mid_edge9", status(), 8'h00);
        step();
        check("mid_edge10", status(), 8'h8A);
        step();
        check("mid_edge11", status(), 8'h2A);
        go_raw = 1'b0;
        quiet(10, "mid_release");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
